mcp3_tag_scoreboard: RTL and testbench
======================================

MCP3_TAG_SCOREBOARD -- requirements
Module: mcp3_tag_scoreboard

Interface
REQ-001 The block SHALL have parameter TAG_W, default 3, giving the tag width; NUM_TAGS = 2**TAG_W (default 8).
REQ-002 The block SHALL have parameter CNT_W, default TAG_W+1, giving the width of the pending-count output.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port set_valid  input  1  allocate request for set_tag this cycle.
REQ-006 Port set_tag  input  TAG_W  binary tag to mark pending.
REQ-007 Port clr_valid  input  1  release request for clr_tag this cycle.
REQ-008 Port clr_tag  input  TAG_W  binary tag to mark free.
REQ-009 Port clear_all  input  1  synchronous flush of all pending tags and sticky errors.
REQ-010 Port set_onehot  output  NUM_TAGS  registered one-hot decode of the last accepted set_tag, pulsed for one cycle.
REQ-011 Port pending  output  NUM_TAGS  registered pending-tag vector; bit i is tag i.
REQ-012 Port pend_count  output  CNT_W  registered population count of pending.
REQ-013 Port empty  output  1  pending all zero.
REQ-014 Port full  output  1  pending all ones.
REQ-015 Port err_dbl_set  output  1  sticky: set to an already-pending tag.
REQ-016 Port err_bad_clr  output  1  sticky: release of a non-pending tag.

Function
REQ-017 Set mask SHALL be one-hot decode of set_tag gated by set_valid; clear mask SHALL be one-hot decode of clr_tag gated by clr_valid.
REQ-018 Next pending SHALL be (pending AND NOT clear mask) OR set mask, updated with 1-cycle latency.
REQ-019 Set and clear of the same tag in one cycle: clear applies first, then set, so the bit SHALL end at 1.
REQ-020 clear_all SHALL take priority over set and clear: next pending = 0, pend_count = 0, set_onehot = 0, both errors cleared.
REQ-021 set_onehot SHALL equal the set mask registered one cycle later; all zero in cycles following set_valid = 0.
REQ-022 pend_count SHALL be computed from next pending and registered with it; never lags pending.
REQ-023 empty SHALL be 1 when pend_count = 0; full SHALL be 1 when pend_count = NUM_TAGS; both combinational from registered state.
REQ-024 Set to a pending tag SHALL leave pending unchanged (idempotent); release of a free tag SHALL leave it unchanged.
REQ-025 No flow control: every set_valid/clr_valid cycle SHALL be accepted, including while full (redundant set) or empty (redundant clear).

Reset
REQ-026 On reset_n low, asynchronously: pending = 0, set_onehot = 0, pend_count = 0, err_dbl_set = 0, err_bad_clr = 0; hence empty = 1, full = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight sets and clears; the first edge after deassertion SHALL process that cycle's inputs normally.

Configuration
REQ-028 Macro MCP3_TAG_SCOREBOARD_ERR_EN defined: err_dbl_set SHALL set when set_valid and pending[set_tag] = 1 and not (clr_valid and clr_tag = set_tag); err_bad_clr SHALL set when clr_valid and pending[clr_tag] = 0; both sticky until clear_all or reset.
REQ-029 Macro undefined: err_dbl_set and err_bad_clr SHALL be tied to 0 and no error flops SHALL be synthesised; all other behaviour identical.

Structure
REQ-030 Shared package mcp3_pkg SHALL hold the default TAG_W constant and a function computing NUM_TAGS from TAG_W.
REQ-031 Sub-module mcp3_decoder_param (combinational, parameter IN_W, binary in, 2**IN_W one-hot out) SHALL be instantiated twice, for set and clear masks.

Verification
REQ-032 Reset, then set tags 0,3,7 on consecutive cycles -> pending = 8'b10001001, pend_count = 3, set_onehot pulses 01h, 08h, 80h.
REQ-033 Set all 8 tags -> full = 1, pend_count = 8; clear tag 5 -> pending = 8'hDF, full = 0.
REQ-034 pending = 8'h10, same cycle set_tag = clr_tag = 4 -> pending stays 8'h10, err_dbl_set = 0.
REQ-035 With ERR_EN: set tag 2 twice -> err_dbl_set = 1 and stays 1; clear tag 6 (free) -> err_bad_clr = 1; clear_all -> both 0, empty = 1.
REQ-036 pending = 8'hFF, clear_all with set_valid tag 1 -> pending = 0, set_onehot = 0; reset_n low mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mcp3_pkg.sv
// Shared constants and helpers for the mcp3 tag scoreboard.
package mcp3_pkg;

    localparam int unsigned TAG_W_DEFAULT = 3;

    // Number of distinct tags addressable by a tag of width w.
    function automatic int unsigned num_tags(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/mcp3_decoder_param.sv
// Combinational binary-to-one-hot decoder, IN_W bits in, 2**IN_W bits out.
module mcp3_decoder_param #(
    parameter int unsigned IN_W = 3
) (
    input  logic [IN_W-1:0]      i_bin,
    output logic [(2**IN_W)-1:0] o_onehot
);

    localparam int unsigned OUT_W = 2 ** IN_W;

    assign o_onehot = OUT_W'(1) << i_bin;

endmodule

// File: rtl/mcp3_tag_scoreboard.sv
// Pending-tag scoreboard with population count and sticky protocol errors.
// Optional error detection enabled by defining MCP3_TAG_SCOREBOARD_ERR_EN.
module mcp3_tag_scoreboard
    import mcp3_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEFAULT,
    parameter int unsigned CNT_W = TAG_W + 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         set_valid,
    input  logic [TAG_W-1:0]             set_tag,
    input  logic                         clr_valid,
    input  logic [TAG_W-1:0]             clr_tag,
    input  logic                         clear_all,
    output logic [num_tags(TAG_W)-1:0]   set_onehot,
    output logic [num_tags(TAG_W)-1:0]   pending,
    output logic [CNT_W-1:0]             pend_count,
    output logic                         empty,
    output logic                         full,
    output logic                         err_dbl_set,
    output logic                         err_bad_clr
);

    localparam int unsigned NUM_TAGS = num_tags(TAG_W);

    logic [NUM_TAGS-1:0] w_set_dec;
    logic [NUM_TAGS-1:0] w_clr_dec;
    logic [NUM_TAGS-1:0] w_set_mask;
    logic [NUM_TAGS-1:0] w_clr_mask;
    logic [NUM_TAGS-1:0] w_pend_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [NUM_TAGS-1:0] r_pend;
    logic [NUM_TAGS-1:0] r_onehot;
    logic [CNT_W-1:0]    r_cnt;

    mcp3_decoder_param #(.IN_W(TAG_W)) u_set_dec (
        .i_bin    (set_tag),
        .o_onehot (w_set_dec)
    );

    mcp3_decoder_param #(.IN_W(TAG_W)) u_clr_dec (
        .i_bin    (clr_tag),
        .o_onehot (w_clr_dec)
    );

    assign w_set_mask = w_set_dec & {NUM_TAGS{set_valid}};
    assign w_clr_mask = w_clr_dec & {NUM_TAGS{clr_valid}};

    // Clear is applied before set, so a same-cycle set/clear of one tag leaves it pending.
    always_comb begin
        w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
        w_cnt_nxt  = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend   <= '0;
            r_onehot <= '0;
            r_cnt    <= '0;
        end else if (clear_all) begin
            r_pend   <= '0;
            r_onehot <= '0;
            r_cnt    <= '0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_onehot <= w_set_mask;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign pending    = r_pend;
    assign set_onehot = r_onehot;
    assign pend_count = r_cnt;
    assign empty      = (r_cnt == '0);
    assign full       = (r_cnt == CNT_W'(NUM_TAGS));

`ifdef MCP3_TAG_SCOREBOARD_ERR_EN
    logic w_dbl_hit;
    logic w_bad_hit;
    logic r_err_dbl;
    logic r_err_bad;

    // A set paired with a same-cycle release of that tag is a legal reuse, not a double set.
    assign w_dbl_hit = set_valid && r_pend[set_tag] && !(clr_valid && (clr_tag == set_tag));
    assign w_bad_hit = clr_valid && !r_pend[clr_tag];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_dbl <= 1'b0;
            r_err_bad <= 1'b0;
        end else if (clear_all) begin
            r_err_dbl <= 1'b0;
            r_err_bad <= 1'b0;
        end else begin
            r_err_dbl <= r_err_dbl | w_dbl_hit;
            r_err_bad <= r_err_bad | w_bad_hit;
        end
    end

    assign err_dbl_set = r_err_dbl;
    assign err_bad_clr = r_err_bad;
`else
    assign err_dbl_set = 1'b0;
    assign err_bad_clr = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3_tag_scoreboard.sv
// Self-checking bench for mcp3_tag_scoreboard (default TAG_W = 3).
module tb_mcp3_tag_scoreboard;

`ifdef MCP3_TAG_SCOREBOARD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       set_valid;
    logic [2:0] set_tag;
    logic       clr_valid;
    logic [2:0] clr_tag;
    logic       clear_all;
    logic [7:0] set_onehot;
    logic [7:0] pending;
    logic [3:0] pend_count;
    logic       empty;
    logic       full;
    logic       err_dbl_set;
    logic       err_bad_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: a set of pending tag numbers plus the last accepted set tag.
    bit m_pend [8];
    int m_last_set;
    bit m_edbl;
    bit m_ebad;

    mcp3_tag_scoreboard dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .set_valid   (set_valid),
        .set_tag     (set_tag),
        .clr_valid   (clr_valid),
        .clr_tag     (clr_tag),
        .clear_all   (clear_all),
        .set_onehot  (set_onehot),
        .pending     (pending),
        .pend_count  (pend_count),
        .empty       (empty),
        .full        (full),
        .err_dbl_set (err_dbl_set),
        .err_bad_clr (err_bad_clr)
    );

    always #5 clock = ~clock;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) v += (32'd1 << i);
        return v;
    endfunction

    function automatic logic [31:0] m_onehot();
        return (m_last_set < 0) ? 32'd0 : (32'd1 << m_last_set);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_last_set = -1;
        m_edbl     = 1'b0;
        m_ebad     = 1'b0;
    endtask

    task automatic m_clock(input bit sv, input int st, input bit cv, input int ct, input bit ca);
        if (ca) begin
            m_reset();
        end else begin
            if (sv && m_pend[st] && !(cv && ct == st)) m_edbl = 1'b1;
            if (cv && !m_pend[ct]) m_ebad = 1'b1;
            if (cv) m_pend[ct] = 1'b0;
            if (sv) m_pend[st] = 1'b1;
            m_last_set = sv ? st : -1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".pending"},    32'(pending),     m_vec());
        chk({where, ".pend_count"}, 32'(pend_count),  32'(m_count()));
        chk({where, ".set_onehot"}, 32'(set_onehot),  m_onehot());
        chk({where, ".empty"},      32'(empty),       32'(m_count() == 0));
        chk({where, ".full"},       32'(full),        32'(m_count() == 8));
        chk({where, ".err_dbl"},    32'(err_dbl_set), 32'(ERR_EN & m_edbl));
        chk({where, ".err_bad"},    32'(err_bad_clr), 32'(ERR_EN & m_ebad));
    endtask

    task automatic step(input string where, input bit sv, input int st, input bit cv, input int ct, input bit ca);
        set_valid = sv;
        set_tag   = 3'(st);
        clr_valid = cv;
        clr_tag   = 3'(ct);
        clear_all = ca;
        @(posedge clock);
        m_clock(sv, st, cv, ct, ca);
        #1;
        check_all(where);
    endtask

    // Assert reset mid-cycle with a set in flight; outputs must drop at once and hold through an edge.
    task automatic mid_reset(input string where);
        set_valid = 1'b1;
        set_tag   = 3'($urandom_range(0, 7));
        clr_valid = 1'b1;
        clr_tag   = 3'($urandom_range(0, 7));
        clear_all = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all({where, ".async"});
        @(posedge clock);
        #1;
        check_all({where, ".held"});
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        set_valid = 1'b0;
        set_tag   = '0;
        clr_valid = 1'b0;
        clr_tag   = '0;
        clear_all = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        chk("reset.empty_const", 32'(empty), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Tags 0, 3, 7 on consecutive cycles
        step("s0", 1, 0, 0, 0, 0);
        chk("s0.onehot_const", 32'(set_onehot), 32'h01);
        step("s3", 1, 3, 0, 0, 0);
        chk("s3.onehot_const", 32'(set_onehot), 32'h08);
        step("s7", 1, 7, 0, 0, 0);
        chk("s7.onehot_const", 32'(set_onehot), 32'h80);
        chk("s7.pending_const", 32'(pending), 32'h89);
        chk("s7.count_const", 32'(pend_count), 32'd3);
        step("idle", 0, 0, 0, 0, 0);

        // Fill all tags, then release tag 5
        for (int t = 0; t < 8; t++) step("fill", 1, t, 0, 0, 0);
        chk("fill.full_const", 32'(full), 32'd1);
        chk("fill.count_const", 32'(pend_count), 32'd8);
        step("full_redundant_set", 1, 2, 0, 0, 0);
        step("clr5", 0, 0, 1, 5, 0);
        chk("clr5.pending_const", 32'(pending), 32'hDF);
        chk("clr5.full_const", 32'(full), 32'd0);

        // Same-cycle set and clear of a pending tag
        step("flush1", 0, 0, 0, 0, 1);
        step("set4", 1, 4, 0, 0, 0);
        step("setclr4", 1, 4, 1, 4, 0);
        chk("setclr4.pending_const", 32'(pending), 32'h10);
        chk("setclr4.err_dbl_const", 32'(err_dbl_set), 32'd0);

        // Double set, bad clear, and flush of sticky errors
        step("flush2", 0, 0, 0, 0, 1);
        step("set2a", 1, 2, 0, 0, 0);
        step("set2b", 1, 2, 0, 0, 0);
        step("idle2", 0, 0, 0, 0, 0);
        step("clr6", 0, 0, 1, 6, 0);
        step("flush3", 0, 0, 0, 0, 1);
        chk("flush3.empty_const", 32'(empty), 32'd1);

        // clear_all beats a concurrent set, then reset lands mid-burst
        for (int t = 0; t < 8; t++) step("fill2", 1, t, 0, 0, 0);
        chk("fill2.pending_const", 32'(pending), 32'hFF);
        step("flush_vs_set", 1, 1, 0, 0, 1);
        chk("flush_vs_set.pending_const", 32'(pending), 32'h00);
        chk("flush_vs_set.onehot_const", 32'(set_onehot), 32'h00);
        step("burst_a", 1, 5, 0, 0, 0);
        step("burst_b", 1, 6, 1, 2, 0);
        mid_reset("rst1");
        step("post_rst", 1, 3, 1, 3, 0);

        // Randomised traffic with occasional flushes and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                mid_reset("rand_rst");
            end else begin
                step("rand",
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     ($urandom_range(0, 39) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
